// File: rtl/wb_mem_responder.sv
// Wishbone classic slave backed by a byte-lane-writable word RAM, with a fixed
// wait-state count and saturating transaction counters for bench bookkeeping.
module wb_mem_responder #(
  parameter int          g_addr_bits   = 8,
  parameter int          g_wait_states = 0,
  parameter logic [31:0] g_oor_data    = 32'hDEADBEEF,
  parameter logic [15:0] g_cnt_max     = 16'hFFFF
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [15:0] wr_count_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] oor_count_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam int          c_depth = 2 ** g_addr_bits;
  localparam logic [3:0]  c_wait  = 4'(g_wait_states);

  // Handshake: a request is cyc & stb held by the initiator until it sees
  // ack for one cycle; the slave never acks without a request taken in IDLE.
  logic [1:0]  r_state;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_done_we;
  logic        r_done_oor;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;
  logic [15:0] r_oor_cnt;
  logic [31:0] r_mem [0:c_depth-1];

  logic                   w_req;
  logic                   w_in_range;
  logic [g_addr_bits-1:0] w_idx;
  logic                   w_commit;

  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_in_range = ((r_adr >> g_addr_bits) == 32'd0);
  assign w_idx      = r_adr[g_addr_bits-1:0];
  assign w_commit   = rst_n_i && (r_state == ST_ACK) && r_we && w_in_range;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= g_cnt_max) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_adr      <= 32'd0;
      r_dat      <= 32'd0;
      r_sel      <= 4'd0;
      r_we       <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= 32'd0;
      r_done_we  <= 1'b0;
      r_done_oor <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
      case (r_state)
        ST_IDLE: begin
          // The strobe still held during ack's cycle belongs to the finished access.
          if (w_req && !r_ack) begin
            r_adr      <= wb_adr_i;
            r_dat      <= wb_dat_i;
            r_sel      <= wb_sel_i;
            r_we       <= wb_we_i;
            r_wait_cnt <= c_wait;
            r_state    <= (c_wait != 4'd0) ? ST_WAIT : ST_ACK;
          end
        end
        ST_WAIT: begin
          if (!w_req) begin
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            if (r_wait_cnt <= 4'd1) r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ack      <= 1'b1;
          r_rdata    <= r_we ? 32'd0 : (w_in_range ? r_mem[w_idx] : g_oor_data);
          r_done_we  <= r_we;
          r_done_oor <= !w_in_range;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Counters lag the ack by one cycle so they only see completed accesses.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      r_wr_cnt  <= 16'd0;
      r_rd_cnt  <= 16'd0;
      r_oor_cnt <= 16'd0;
    end else if (r_ack) begin
      if (r_done_we) r_wr_cnt <= sat_inc(r_wr_cnt);
      else           r_rd_cnt <= sat_inc(r_rd_cnt);
      if (r_done_oor) r_oor_cnt <= sat_inc(r_oor_cnt);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (r_sel[k]) r_mem[w_idx][8*k +: 8] <= r_dat[8*k +: 8];
      end
    end
  end

  assign wb_ack_o    = r_ack;
  assign wb_dat_o    = r_rdata;
  assign wr_count_o  = r_wr_cnt;
  assign rd_count_o  = r_rd_cnt;
  assign oor_count_o = r_oor_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Synthesizable Wishbone classic (non-pipelined) slave for simulation benches and bring-up. It is the responder end of the bench Wishbone initiator. It provides a byte-lane-writable word RAM with a fixed, parameterizable wait-state count. Saturating access counters let a bench confirm that the expected number of transactions reached the slave.

## Interface
- g_addr_bits, 8: number of word-address bits decoded; RAM depth is 2**g_addr_bits 32-bit words.
- g_wait_states, 0: extra cycles inserted between request capture and ack; legal range 0..15.
- g_oor_data, 32'hDEADBEEF: read data returned for out-of-range addresses.
- clk_sys_i, in, 1: system clock; all logic is on its rising edge.
- rst_n_i, in, 1: reset, synchronous, active-low.
- wb_adr_i, in, 32: word address; the initiator has already shifted the byte address right by 2.
- wb_dat_i, in, 32: write data.
- wb_dat_o, out, 32: read data; valid only while wb_ack_o=1.
- wb_sel_i, in, 4: byte lane enables; bit k enables byte lane [8k+7:8k].
- wb_cyc_i, in, 1: bus cycle.
- wb_stb_i, in, 1: strobe.
- wb_we_i, in, 1: 1 = write, 0 = read.
- wb_ack_o, out, 1: single-cycle acknowledge.
- wr_count_o, out, 16: number of acked writes; saturates at 16'hFFFF.
- rd_count_o, out, 16: number of acked reads; saturates at 16'hFFFF.
- oor_count_o, out, 16: number of acked out-of-range accesses, reads and writes; saturates at 16'hFFFF.

## Operation
- The FSM has three states: IDLE, WAIT, ACK.
- IDLE:
  - On an edge where wb_cyc_i & wb_stb_i = 1, capture the address, write data, sel and we into request registers.
  - Load the wait counter with g_wait_states.
  - Go to WAIT if g_wait_states > 0, otherwise go to ACK.
- WAIT:
  - Decrement the wait counter each cycle; go to ACK when it reaches 1.
  - If wb_cyc_i = 0 or wb_stb_i = 0 on any WAIT edge, abort and return to IDLE. An aborted request produces no RAM write, no ack and no counter update.
- ACK:
  - wb_ack_o = 1 for exactly one cycle.
  - On a write, commit to RAM during this cycle.
  - Always return to IDLE next. A new request is not captured in the cycle the FSM leaves ACK, so a back-to-back strobe is captured one cycle later.
  - If cyc/stb drop in the ACK cycle itself, the access still completes, because the commit is already decided.
- In-range test: wb_adr_i[31:g_addr_bits] == 0.
- In-range write: for each k with sel[k] = 1, mem[adr][8k+7:8k] <= dat[8k+7:8k]; other lanes are unchanged. sel = 0000 is acked and changes nothing.
- In-range read: wb_dat_o = full 32-bit mem[adr]; sel is ignored for reads.
- Out-of-range access:
  - Always acked, so the initiator never hangs.
  - Write data is discarded.
  - Read returns g_oor_data.
  - Increments oor_count_o together with wr_count_o or rd_count_o.
- Counters increment in the cycle after the ack cycle and stop at 16'hFFFF, with no wrap.
- The RAM is not cleared by reset. Its contents are undefined until written; the bench initializes it.

## Timing
- Reset (rst_n_i = 0 at an edge):
  - FSM goes to IDLE.
  - wb_ack_o = 0, wb_dat_o = 0.
  - All counters = 0.
  - The wait counter is cleared.
  - Reset mid-transaction drops the request without writing or acking.
- Latency: request sampled at edge N; wb_ack_o is high during the cycle following edge N+1+g_wait_states and low again after the next edge.
- wb_dat_o is registered; it is loaded in the same edge that raises ack and is driven back to 0 when ack falls.
- wb_ack_o is never high for two consecutive cycles.
- wb_ack_o is never asserted without a request captured in IDLE.
- Throughput: one access per g_wait_states + 3 cycles (capture, waits, ack, turnaround).

## Test plan
- Full-word round trip, g_wait_states = 0: write 32'h12345678 to word 5, then read word 5 -> read data 32'h12345678; ack is 1 cycle wide at 2 cycles latency; wr_count_o = 1, rd_count_o = 1.
- Byte lanes:
  - Write 32'hFFFFFFFF to word 0.
  - Write 32'hAA000000 with sel = 1000 -> read gives 32'hAAFFFFFF.
  - Write 32'h00001234 with sel = 0011 -> read gives 32'hAAFF1234.
- Wait states, g_wait_states = 3: ack asserted exactly 5 cycles after the request edge; 10 back-to-back writes take 60 cycles; wr_count_o = 10.
- Out of range, g_addr_bits = 8: write to word 32'h100, then read it -> ack received, read data 32'hDEADBEEF, word 0 unchanged, oor_count_o = 2.
- Abort and reset:
  - Drop cyc during WAIT -> no ack, memory and counters unchanged.
  - Assert rst_n_i = 0 during WAIT -> ack stays 0, counters read 0; the next access completes normally.
- Saturation: 65 540 reads -> rd_count_o holds 16'hFFFF.
